// File: rtl/comp2s_seq_ctrl_if.sv
// Request-side bus of the nibble-serial two's-complement sequencer.
// The master issues start/operand; the slave returns status and the held result.
interface comp2s_seq_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  logic                   start;
  logic [4*NIBBLES-1:0]   operand;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   result;
  logic                   ovf;
  logic                   zero;

  modport master (
    output start, operand,
    input  busy, done, result, ovf, zero
  );

  modport slave (
    input  start, operand,
    output busy, done, result, ovf, zero
  );
endinterface

// File: rtl/comp2s_seq_ctrl.sv
// Negates a W-bit operand by walking a shared 4-bit ~A+Cin unit from the low nibble up,
// chaining its carry and assembling the result one nibble per cycle.
//
// state | meaning
// IDLE  | waiting for start; comp_* held at 0
// RUN   | one nibble per cycle through the external 4-bit unit
// DONE  | one-cycle done pulse; result/ovf/zero valid and held afterwards
module comp2s_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  comp2s_seq_ctrl_if.slave   req,
  output logic [3:0]         comp_a,
  output logic               comp_cin,
  input  logic [3:0]         comp_b,
  input  logic               comp_cout
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            idx;
  logic                     carry;
  logic [NIBBLES-1:0][3:0]  op_reg;
  logic [NIBBLES-1:0][3:0]  res_reg;
  logic                     ovf_reg;
  logic                     zero_reg;
  logic                     last_nib;

  assign last_nib = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req.start) state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req.busy   = (state != IDLE);
    req.done   = (state == DONE);
    req.result = res_reg;
    req.ovf    = ovf_reg;
    req.zero   = zero_reg;
    comp_a     = 4'h0;
    comp_cin   = 1'b0;
    if (state == RUN) begin
      comp_a   = op_reg[idx];
      comp_cin = carry;
    end
  end

  // The 4-bit unit is combinational, so its answer is captured in the cycle it is driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      op_reg   <= '0;
      res_reg  <= '0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req.start) begin
            op_reg   <= req.operand;
            idx      <= '0;
            carry    <= 1'b1;
            res_reg  <= '0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
          end
        end
        RUN: begin
          res_reg[idx] <= comp_b;
          carry        <= comp_cout;
          idx          <= idx + IW'(1);
          if (last_nib) begin
            // Final carry out is set only when every nibble was zero.
            zero_reg <= comp_cout;
            ovf_reg  <= op_reg[NIBBLES-1][3] & comp_b[3];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp2s_seq_ctrl.sv
// Randomized scoreboard bench for comp2s_seq_ctrl with a behavioural 4-bit complement unit.
module tb_comp2s_seq_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp2s_seq_ctrl_if #(.NIBBLES(NIBBLES)) req_if ();

  logic [3:0] comp_a, comp_b;
  logic       comp_cin, comp_cout;

  // Shared 4-bit unit: B = ~A + Cin, Cout is the carry out of that sum.
  assign {comp_cout, comp_b} = {1'b0, ~comp_a} + 5'(comp_cin);

  comp2s_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_if),
    .comp_a    (comp_a),
    .comp_cin  (comp_cin),
    .comp_b    (comp_b),
    .comp_cout (comp_cout)
  );

  typedef struct {
    logic [W-1:0] op;
    logic [W-1:0] res;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           edge_n = 0;
  int           free_edge = 0;
  logic [W-1:0] held_res = '0;
  logic         held_ovf = 1'b0;
  logic         held_zero = 1'b0;
  bit           mon_en = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [3:0] nib(input logic [W-1:0] op, input int k);
    return 4'(op >> (4 * k));
  endfunction

  // Carry into nibble k is 1 exactly when every lower bit of the operand is zero.
  function automatic logic cin_of(input logic [W-1:0] op, input int k);
    logic [W-1:0] mask;
    if (k == 0) return 1'b1;
    mask = (W'(1) << (4 * k)) - W'(1);
    return (op & mask) == '0;
  endfunction

  always @(negedge clk) begin
    int   k;
    bit   active;
    exp_t e;
    if (mon_en) begin
      active = 1'b0;
      k = 0;
      if (sb.size() > 0) begin
        k = edge_n - sb[0].acc;
        active = (k >= 0);
      end
      if (active && k < NIBBLES) begin
        check("busy_run", req_if.busy, 1);
        check("done_run", req_if.done, 0);
        check("comp_a", comp_a, nib(sb[0].op, k));
        check("comp_cin", comp_cin, cin_of(sb[0].op, k));
      end else if (active) begin
        e = sb.pop_front();
        check("busy_done", req_if.busy, 1);
        check("done_pulse", req_if.done, 1);
        check("result", req_if.result, e.res);
        check("ovf", req_if.ovf, e.ovf);
        check("zero", req_if.zero, e.zero);
        held_res  = e.res;
        held_ovf  = e.ovf;
        held_zero = e.zero;
      end else begin
        check("busy_idle", req_if.busy, 0);
        check("done_idle", req_if.done, 0);
        check("comp_a_idle", comp_a, 0);
        check("comp_cin_idle", comp_cin, 0);
        check("result_held", req_if.result, held_res);
        check("ovf_held", req_if.ovf, held_ovf);
        check("zero_held", req_if.zero, held_zero);
      end
    end
  end

  // Drive one cycle of inputs; the model decides whether the start is accepted.
  task automatic cyc(input logic s, input logic [W-1:0] op, output bit acc);
    exp_t e;
    req_if.start   = s;
    req_if.operand = op;
    acc = 1'b0;
    if (s && (edge_n + 1 >= free_edge)) begin
      e.op   = op;
      e.res  = W'(0) - op;
      e.ovf  = (op == {1'b1, {(W-1){1'b0}}});
      e.zero = (op == '0);
      e.acc  = edge_n + 1;
      sb.push_back(e);
      free_edge = edge_n + 1 + NIBBLES + 2;
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
    req_if.start   = 1'b0;
    req_if.operand = W'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] op);
    bit acc;
    while (edge_n + 1 < free_edge) cyc(1'b0, W'($urandom), acc);
    cyc(1'b1, op, acc);
  endtask

  initial begin
    bit           acc;
    logic         s;
    logic [W-1:0] op;
    req_if.start   = 1'b0;
    req_if.operand = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", req_if.busy, 0);
    check("rst_done", req_if.done, 0);
    check("rst_result", req_if.result, 0);
    check("rst_ovf", req_if.ovf, 0);
    check("rst_zero", req_if.zero, 0);
    check("rst_comp_a", comp_a, 0);
    check("rst_comp_cin", comp_cin, 0);
    rst_n = 1'b1;
    free_edge = edge_n + 1;
    mon_en = 1'b1;

    run_op(16'h0004);
    run_op(16'h0007);
    run_op(16'h0000);
    run_op(16'h8000);
    run_op(16'h7FFF);

    // Start during RUN must be ignored by the DUT and by the model alike.
    run_op(16'h00A5);
    cyc(1'b1, 16'h1234, acc);
    check("busy_start_ignored", acc, 0);

    // Reset in the second RUN cycle abandons the operation.
    run_op(16'h5A5A);
    cyc(1'b0, W'($urandom), acc);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", req_if.busy, 0);
    check("mid_rst_done", req_if.done, 0);
    check("mid_rst_result", req_if.result, 0);
    check("mid_rst_comp_a", comp_a, 0);
    check("mid_rst_comp_cin", comp_cin, 0);
    sb.delete();
    held_res  = '0;
    held_ovf  = 1'b0;
    held_zero = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    free_edge = edge_n + 1;
    run_op(16'h0001);

    repeat (400) begin
      s = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       op = 16'h0000;
        1:       op = 16'h8000;
        2:       op = 16'h7FFF;
        3:       op = 16'hFFFF;
        4:       op = 16'h0010;
        default: op = W'($urandom);
      endcase
      cyc(s, op, acc);
    end

    repeat (NIBBLES + 3) cyc(1'b0, W'($urandom), acc);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/comp2s_seq_ctrl.md
Name: comp2s_seq_ctrl

Overview:
Sequencer that computes the two's complement of a wide operand by driving the team's shared 4-bit two's-complement datapath one nibble per cycle.
- The 4-bit unit computes B = ~A + Cin and produces Cout.
- The controller chains the carry from the least-significant nibble upward and assembles the result.
- It reports done, overflow and zero status.
- It sits between a requesting block (start/operand) and one instance of the 4-bit complement unit.

Parameters:
NIBBLES, 4, number of 4-bit slices in the operand; W = 4*NIBBLES (minimum 1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request pulse; sampled only in IDLE.
operand  input  W  value to negate; captured on the accepted start.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when result is valid.
result  output  W  two's complement of the captured operand; held until the next accepted start.
ovf  output  1  operand was the most-negative value (1 followed by W-1 zeros); valid with done, held.
zero  output  1  operand was 0 (final carry out = 1); valid with done, held.
comp_a  output  4  nibble driven to the 4-bit unit's A.
comp_cin  output  1  carry driven to the 4-bit unit's Cin.
comp_b  input  4  4-bit unit's B.
comp_cout  input  1  4-bit unit's Cout.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, ovf=0, zero=0, comp_a=0, comp_cin=0; internal index=0, carry=0, operand register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - comp_a=0, comp_cin=0.
  - start=1 → latch operand, idx<=0, carry<=1, clear result, go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - comp_a = op_reg[4*idx+3:4*idx], comp_cin = carry. Both are combinational from registered state.
  - At the clock edge: result[4*idx+3:4*idx] <= comp_b, carry <= comp_cout, idx <= idx+1.
  - The 4-bit unit is combinational; its output is captured in the same cycle it is driven.
  - When idx = NIBBLES-1 at the edge → go to DONE.
  - In the same edge, set zero <= comp_cout and ovf <= op_reg[W-1] & comp_b[3].
- DONE: done=1 for exactly this cycle, then go to IDLE. comp_a=0, comp_cin=0.
- Latency: start accepted at edge 0; RUN occupies NIBBLES cycles; done is high in cycle NIBBLES+1; busy is high from cycle 1 through the done cycle.
- Throughput: one operation per NIBBLES+2 cycles. A start may be accepted in the cycle after DONE.
- start while busy (RUN or DONE) is ignored. It is not queued. The operand input is don't-care outside the accepting cycle.
- result, ovf and zero remain stable from done until the next accepted start. They are cleared when that start is accepted.
- Wrap-around is inherent in modular arithmetic:
  - operand 0 → result 0, zero=1.
  - most-negative operand → result equals operand, ovf=1.
- Reset mid-RUN: the operation is abandoned, all outputs return to reset values, and no done is issued.
- NIBBLES=1 degenerates to a single RUN cycle; idx width = max(1, clog2(NIBBLES)).

Test Plan:
- NIBBLES=4, operand=16'h0004, start 1 cycle → comp_cin=1 on first RUN cycle; done in cycle 5; result=16'hFFFC, ovf=0, zero=0.
- operand=16'h0007 → result=16'hFFF9; on the 2nd RUN cycle, comp_a=4'h0 and comp_cin=0.
- operand=16'h0000 → result=16'h0000, zero=1; comp_cin=1 on all four RUN cycles.
- operand=16'h8000 → result=16'h8000, ovf=1; then operand=16'h7FFF → result=16'h8001, ovf=0, and the flags update.
- Second start pulsed in RUN with operand=16'h1234 → ignored; the first result completes unchanged; busy stays high until done.
- rst_n low during the 2nd RUN cycle → busy, done, result and comp_* go to 0 immediately; no done pulse. The next start with 16'h0001 → result=16'hFFFF.
